// File: rtl/rgbw_fade_scheduler_pkg.sv
// Shared constants and types for the RGBW fade scheduler slice.
package rgbw_pkg;
  localparam int NUM_CH    = 4;
  localparam int CH_R      = 0;
  localparam int CH_G      = 1;
  localparam int CH_B      = 2;
  localparam int CH_W      = 3;
  localparam int DW_DEF    = 8;
  localparam int DIV_W_DEF = 8;

  typedef enum logic {IDLE, FADE} state_e;
endpackage

// File: rtl/rgbw_fade_scheduler_if.sv
// Shadow-load / commit bus between pin decode and the fade scheduler.
interface rgbw_fade_scheduler_if #(parameter int DW = 8);
  logic          load_valid;
  logic          load_ready;
  logic [1:0]    load_ch;
  logic [DW-1:0] load_data;
  logic          commit;

  modport master (output load_valid, load_ch, load_data, commit, input load_ready);
  modport slave  (input load_valid, load_ch, load_data, commit, output load_ready);
endinterface

// File: rtl/rgbw_fade_scheduler_pwm_gen.sv
// Shared free-running PWM counter; compare values latch only at wrap so duty
// changes never cut a period short.
module rgbw_pwm_gen import rgbw_pkg::*; #(
  parameter int DW = DW_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ena,
  input  logic [NUM_CH-1:0][DW-1:0]  cur,
  output logic [NUM_CH-1:0]          pwm
);
  logic [DW-1:0]              r_cnt;
  logic [NUM_CH-1:0][DW-1:0]  r_act;
  logic [NUM_CH-1:0]          r_pwm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_act <= '0;
      r_pwm <= '0;
    end else if (ena) begin
      r_cnt <= r_cnt + DW'(1);
      if (&r_cnt) r_act <= cur;
      for (int i = 0; i < NUM_CH; i++) r_pwm[i] <= (r_cnt < r_act[i]);
    end else begin
      r_pwm <= '0;
    end
  end

  assign pwm = r_pwm;
endmodule

// File: rtl/rgbw_fade_scheduler.sv
// Shadow/target duty registers, fade prescaler and IDLE/FADE sequencer
// driving the shared PWM generator.
module rgbw_fade_scheduler import rgbw_pkg::*; #(
  parameter int DW    = DW_DEF,
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ena,
  rgbw_fade_scheduler_if.slave   bus,
  input  logic [DIV_W-1:0]       fade_div,
  output logic [NUM_CH-1:0]      pwm_out,
  output logic                   busy,
  output logic                   done,
  output logic [NUM_CH*DW-1:0]   cur_duty
);
  logic [NUM_CH-1:0][DW-1:0] r_shadow, r_tgt, r_cur;
  logic [NUM_CH-1:0][DW-1:0] w_shadow_nxt, w_tgt_nxt, w_cur_nxt;
  logic [DIV_W-1:0]          r_pre, w_pre_nxt;
  state_e                    r_state, w_state_nxt;
  logic                      r_busy, r_done, w_wr, w_commit, w_tick;

  assign bus.load_ready = ena;
  assign w_wr     = ena & bus.load_valid;
  assign w_commit = ena & bus.commit;

  // Write-through: a load in the commit cycle reaches the target directly.
  always_comb begin
    w_shadow_nxt = r_shadow;
    if (w_wr) w_shadow_nxt[bus.load_ch] = bus.load_data;
    w_tgt_nxt = w_commit ? w_shadow_nxt : r_tgt;
  end

  // Steps head for the post-commit target so a retarget takes effect at once.
  always_comb begin
    w_state_nxt = r_state;
    w_pre_nxt   = r_pre;
    w_cur_nxt   = r_cur;
    w_tick      = 1'b0;
    case (r_state)
      IDLE: begin
        w_pre_nxt = '0;
        if (w_commit) w_state_nxt = FADE;
      end
      FADE: begin
        if (fade_div == '0) begin
          w_cur_nxt = w_tgt_nxt;
        end else begin
          if (r_pre >= fade_div - DIV_W'(1)) begin
            w_tick    = 1'b1;
            w_pre_nxt = '0;
          end else begin
            w_pre_nxt = r_pre + DIV_W'(1);
          end
          if (w_tick) begin
            for (int i = 0; i < NUM_CH; i++) begin
              if (r_cur[i] < w_tgt_nxt[i])      w_cur_nxt[i] = r_cur[i] + DW'(1);
              else if (r_cur[i] > w_tgt_nxt[i]) w_cur_nxt[i] = r_cur[i] - DW'(1);
            end
          end
        end
        if (w_cur_nxt == w_tgt_nxt) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= '0;
      r_tgt    <= '0;
      r_cur    <= '0;
      r_pre    <= '0;
      r_state  <= IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= ena && (r_state == FADE) && (w_state_nxt == IDLE);
      if (ena) begin
        r_shadow <= w_shadow_nxt;
        r_tgt    <= w_tgt_nxt;
        r_cur    <= w_cur_nxt;
        r_pre    <= w_pre_nxt;
        r_state  <= w_state_nxt;
        r_busy   <= (w_state_nxt == FADE) && (w_cur_nxt != w_tgt_nxt);
      end
    end
  end

  rgbw_pwm_gen #(.DW(DW)) u_pwm (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .cur   (r_cur),
    .pwm   (pwm_out)
  );

  assign busy     = r_busy;
  assign done     = r_done;
  assign cur_duty = r_cur;
endmodule

// File: tb/tb_rgbw_fade_scheduler.sv
// Directed bench: stimulus pushes expected cur_duty per fade completion,
// a monitor pops and compares on every done pulse.
module tb_rgbw_fade_scheduler;
  import rgbw_pkg::*;
  localparam int DW = 8, DIV_W = 8;

  logic             clk = 1'b0, rst_n = 1'b0, ena = 1'b1;
  logic [DIV_W-1:0] fade_div = '0;
  logic [3:0]       pwm_out;
  logic             busy, done;
  logic [31:0]      cur_duty;

  rgbw_fade_scheduler_if #(.DW(DW)) bus();

  rgbw_fade_scheduler #(.DW(DW), .DIV_W(DIV_W)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .bus(bus.slave),
    .fade_div(fade_div), .pwm_out(pwm_out), .busy(busy), .done(done),
    .cur_duty(cur_duty)
  );

  always #5 clk = ~clk;

  int          checks = 0, failures = 0, skip_errs = 0;
  logic [31:0] exp_q[$];
  logic [31:0] prev_cur = '0;
  bit          step_watch = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every done pulse must match the oldest expected snapshot.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL done_unexpected actual=%h expected=no_done", cur_duty);
      end else begin
        chk("done_cur_duty", cur_duty, exp_q.pop_front());
      end
    end
    if (step_watch)
      for (int i = 0; i < 4; i++) begin
        int d;
        d = int'(cur_duty[i*8 +: 8]) - int'(prev_cur[i*8 +: 8]);
        if (d > 1 || d < -1) skip_errs++;
      end
    prev_cur = cur_duty;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [1:0] ch, input logic [7:0] data);
    bus.load_valid = 1'b1; bus.load_ch = ch; bus.load_data = data;
    tick();
    bus.load_valid = 1'b0;
  endtask

  task automatic do_commit();
    bus.commit = 1'b1;
    tick();
    bus.commit = 1'b0;
  endtask

  initial begin
    int n, lows, hi[4], bad_pwm, bad_cur;
    logic [31:0] frozen;
    bus.load_valid = 1'b0; bus.load_ch = '0; bus.load_data = '0; bus.commit = 1'b0;

    // Reset held with random activity on the inputs
    for (int i = 0; i < 6; i++) begin
      bus.load_valid = 1'($urandom); bus.load_ch = 2'($urandom);
      bus.load_data = 8'($urandom); bus.commit = 1'($urandom);
      fade_div = 8'($urandom);
      tick();
    end
    chk("rst_pwm", pwm_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cur", cur_duty, 0);
    chk("rst_ready", bus.load_ready, 1);
    bus.load_valid = 1'b0; bus.commit = 1'b0; fade_div = '0;
    @(negedge clk); #2 rst_n = 1'b1;
    tick();
    chk("rel_pwm", pwm_out, 0);
    chk("rel_cur", cur_duty, 0);
    chk("rel_done", done, 0);

    // Immediate load: R=0x40, W=0xFF, fade_div=0
    write(CH_R, 8'h40);
    write(CH_W, 8'hFF);
    exp_q.push_back(32'hFF00_0040);
    do_commit();
    tick();
    chk("imm_done_latency", done, 1);
    repeat (300) tick();
    for (int i = 0; i < 4; i++) hi[i] = 0;
    for (int c = 0; c < 256; c++) begin
      for (int i = 0; i < 4; i++) hi[i] += pwm_out[i];
      tick();
    end
    chk("pwm_r_high", hi[0], 64);
    chk("pwm_g_high", hi[1], 0);
    chk("pwm_b_high", hi[2], 0);
    chk("pwm_w_high", hi[3], 255);

    // Timed fade G 0 -> 0x10 at fade_div=4
    fade_div = 8'd4;
    write(CH_G, 8'h10);
    exp_q.push_back(32'hFF00_1040);
    step_watch = 1'b1;
    do_commit();
    n = 0; lows = 0;
    while (!done && n < 200) begin
      if (!busy) lows++;
      tick();
      n++;
      if (n == 32) chk("timed_mid_g", cur_duty[15:8], 8'h08);
    end
    chk("timed_cycles", n, 64);
    chk("timed_busy_lows", lows, 0);
    chk("timed_busy_after", busy, 0);

    // Retarget B 0 -> 0x80 at fade_div=2, recommit 0x20 when B hits 0x30
    fade_div = 8'd2;
    write(CH_B, 8'h80);
    do_commit();
    n = 0;
    while (cur_duty[23:16] != 8'h30 && n < 1000) begin tick(); n++; end
    chk("retarget_reach_30", cur_duty[23:16], 8'h30);
    exp_q.push_back(32'hFF20_1040);
    bus.load_valid = 1'b1; bus.load_ch = CH_B; bus.load_data = 8'h20; bus.commit = 1'b1;
    tick();
    bus.load_valid = 1'b0; bus.commit = 1'b0;
    n = 0;
    while (!done && n < 200) begin tick(); n++; end
    chk("retarget_final_b", cur_duty[23:16], 8'h20);
    step_watch = 1'b0;

    // Same-cycle load and commit, fade_div=0
    fade_div = '0;
    exp_q.push_back(32'hFF20_5540);
    bus.load_valid = 1'b1; bus.load_ch = CH_G; bus.load_data = 8'h55; bus.commit = 1'b1;
    tick();
    bus.load_valid = 1'b0; bus.commit = 1'b0;
    tick();
    chk("samecyc_g", cur_duty[15:8], 8'h55);

    // Pause: R 0x40 -> 0 at fade_div=4 (256 active clocks), ena low for 20
    fade_div = 8'd4;
    write(CH_R, 8'h00);
    exp_q.push_back(32'hFF20_5500);
    step_watch = 1'b1;
    do_commit();
    repeat (40) tick();
    frozen = cur_duty;
    ena = 1'b0;
    bad_pwm = 0; bad_cur = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (pwm_out != 4'b0) bad_pwm++;
      if (cur_duty != frozen) bad_cur++;
    end
    chk("pause_pwm_nonzero", bad_pwm, 0);
    chk("pause_cur_moved", bad_cur, 0);
    ena = 1'b1;
    n = 0;
    while (!done && n < 400) begin tick(); n++; end
    chk("pause_remaining", n, 216);
    step_watch = 1'b0;

    // Async reset mid-fade: immediate zero, no done
    write(CH_B, 8'h00);
    do_commit();
    repeat (10) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_cur", cur_duty, 0);
    chk("arst_busy", busy, 0);
    chk("arst_pwm", pwm_out, 0);
    chk("arst_done", done, 0);
    repeat (3) tick();
    @(negedge clk); #2 rst_n = 1'b1;
    repeat (4) tick();
    chk("post_rst_cur", cur_duty, 0);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_ready", bus.load_ready, 1);

    chk("pending_done", exp_q.size(), 0);
    chk("step_skips", skip_errs, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
